// File: rtl/binary_divider.sv
// rtl/binary_divider.sv - radix-2 restoring significand divider, one quotient bit per clock
// Mq = floor(M1*2^(QBITS-1)/M2), sticky flags a nonzero remainder, valid/ready on both sides.
module binary_divider #(
  parameter int WIDTH = 24,
  parameter int QBITS = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] M1,
  input  logic [WIDTH-1:0] M2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QBITS-1:0] Mq,
  output logic             sticky,
  output logic             div_zero
);

  localparam int CW = $clog2(QBITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvs;
  logic [QBITS-1:0] quo;
  logic [CW-1:0]    count;
  logic             dz;

  logic             ge;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_next;
  logic [QBITS-1:0] quo_next;

  // One restoring step: trial subtract, keep it if it did not go negative, then shift.
  assign ge       = (rem >= {1'b0, dvs});
  assign diff     = ge ? (rem - {1'b0, dvs}) : rem;
  assign rem_next = {diff[WIDTH-1:0], 1'b0};
  assign quo_next = {quo[QBITS-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Mq        <= '0;
      sticky    <= 1'b0;
      div_zero  <= 1'b0;
      count     <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem      <= {1'b0, M1};
            dvs      <= M2;
            quo      <= '0;
            count    <= CW'(QBITS);
            dz       <= (M2 == '0);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (dz) begin
            // Zero divisor skips the iterations and reports a saturated quotient.
            state     <= DONE;
            out_valid <= 1'b1;
            Mq        <= '1;
            sticky    <= 1'b0;
            div_zero  <= 1'b1;
            count     <= '0;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              Mq        <= quo_next;
              sticky    <= (rem_next != '0);
              div_zero  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
